// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial sequencer: mode codes, butterfly
// select codes and FSM state encodings.
package poly_pkg;

  typedef enum logic [1:0] {
    M_DATAIN = 2'd0,
    M_NTT    = 2'd1,
    M_INTT   = 2'd2,
    M_BYPASS = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    BS_NTT    = 2'd0,
    BS_INTT   = 2'd1,
    BS_BYPASS = 2'd2
  } bsel_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  // Butterfly select driven for a given job mode (DATAIN never uses it).
  function automatic bsel_e mode_to_bsel(input mode_e m);
    case (m)
      M_INTT:   return BS_INTT;
      M_BYPASS: return BS_BYPASS;
      default:  return BS_NTT;
    endcase
  endfunction

endpackage

// File: rtl/poly_sched_if.sv
// Command and datapath-control bundle of the polynomial sequencer.
// master = sequencer side, slave = datapath / command issuer side.
interface poly_sched_if #(
  parameter int ADDWID  = 5,
  parameter int ROMAWID = 7
) ();

  logic [1:0]         mode;
  logic               run;
  logic               abort;
  logic               data_vld;
  logic [ADDWID-1:0]  ram_ra;
  logic [ADDWID-1:0]  ram_wa;
  logic               ram_we;
  logic               ram_wsel;
  logic [ROMAWID-1:0] rom_addr;
  logic [1:0]         but_sel;
  logic               busy;
  logic               done;

  modport master (
    input  mode, run, abort, data_vld,
    output ram_ra, ram_wa, ram_we, ram_wsel, rom_addr, but_sel, busy, done
  );

  modport slave (
    output mode, run, abort, data_vld,
    input  ram_ra, ram_wa, ram_we, ram_wsel, rom_addr, but_sel, busy, done
  );

endinterface

// File: rtl/poly_sched_dly.sv
// Write-back delay line: carries (valid, addr) of each issued read for LAT
// cycles so the butterfly result is written to the word it was read from.
// i_flush empties the line on the next edge.
module poly_sched_dly #(
  parameter int LAT = 6,
  parameter int AW  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_vld,
  input  logic [AW-1:0] i_addr,
  output logic          o_vld,
  output logic [AW-1:0] o_addr
);

  logic [LAT-1:0] r_vld;
  logic [AW-1:0]  r_addr [LAT];

  // Valid bits shift each cycle; cleared by reset or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
    end else if (i_flush) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_vld;
      for (int i = 1; i < LAT; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  // Address payload shifts alongside the valid bits.
  // NOTE: the address array is never consumed without its valid bit, so it is deliberately left unreset.
  always_ff @(posedge clk) begin
    r_addr[0] <= i_addr;
    for (int i = 1; i < LAT; i++) r_addr[i] <= r_addr[i-1];
  end

  assign o_vld  = r_vld[LAT-1];
  assign o_addr = r_addr[LAT-1];

endmodule

// File: rtl/poly_sched.sv
// Polynomial datapath sequencer: data load, multi-pass NTT/INTT and bypass
// jobs, driving RAM/ROM addresses and butterfly select with write-back
// latency compensation.
// Optional feature: define POLY_SCHED_PERF_EN to add the perf_cyc busy-cycle
// counter output (latched at done, saturating at 16'hFFFF).
module poly_sched
  import poly_pkg::*;
#(
  parameter int ADDWID   = 5,
  parameter int NPASS    = 3,
  parameter int PIPE_LAT = 6,
  parameter int ROMAWID  = 7
) (
  input  logic          clk,
  input  logic          rst,
  poly_sched_if.master  bus
`ifdef POLY_SCHED_PERF_EN
  ,
  output logic [15:0]   perf_cyc
`endif
);

  localparam int PWID = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam logic [ADDWID-1:0] LAST_WORD = {ADDWID{1'b1}};

  state_e            r_state, w_next;
  mode_e             r_mode;
  logic [ADDWID-1:0] r_word;
  logic [ADDWID-1:0] r_beat;
  logic [PWID-1:0]   r_pass;

  logic              w_start;
  logic              w_last_pass;
  logic              w_last_write;
  logic              w_dly_vld;
  logic [ADDWID-1:0] w_dly_addr;

  // abort beats run when both arrive in IDLE.
  assign w_start      = (r_state == S_IDLE) && bus.run && !bus.abort;
  assign w_last_pass  = (r_mode == M_BYPASS) || (r_pass == PWID'(NPASS - 1));
  assign w_last_write = w_dly_vld && (w_dly_addr == LAST_WORD);

  poly_sched_dly #(
    .LAT (PIPE_LAT),
    .AW  (ADDWID)
  ) u_dly (
    .clk     (clk),
    .rst     (rst),
    .i_flush (bus.abort),
    .i_vld   (r_state == S_ISSUE),
    .i_addr  (r_word),
    .o_vld   (w_dly_vld),
    .o_addr  (w_dly_addr)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; DRAIN leaves on the last delayed write of the pass.
  // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
  always_comb begin
    w_next = r_state;
    if (bus.abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.run) w_next = (mode_e'(bus.mode) == M_DATAIN) ? S_LOAD : S_ISSUE;
        S_LOAD:  if (bus.data_vld && (r_beat == LAST_WORD)) w_next = S_FIN;
        S_ISSUE: if (r_word == LAST_WORD) w_next = S_DRAIN;
        S_DRAIN: if (w_last_write) w_next = w_last_pass ? S_FIN : S_ISSUE;
        S_FIN:   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Mode latch plus word, beat and pass counters (all wrap at their natural width).
  // NOTE: sequential state is updated only with non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode <= M_DATAIN;
      r_word <= '0;
      r_beat <= '0;
      r_pass <= '0;
    end else if (bus.abort) begin
      r_word <= '0;
      r_beat <= '0;
      r_pass <= '0;
    end else begin
      if (w_start) begin
        r_mode <= mode_e'(bus.mode);
        r_word <= '0;
        r_beat <= '0;
        r_pass <= '0;
      end
      if (r_state == S_ISSUE) r_word <= r_word + ADDWID'(1);
      if ((r_state == S_LOAD) && bus.data_vld) r_beat <= r_beat + ADDWID'(1);
      if ((r_state == S_DRAIN) && w_last_write && !w_last_pass) r_pass <= r_pass + PWID'(1);
    end
  end

  // Output decode from state, counters and the delay-line head.
  always_comb begin
    bus.ram_ra   = '0;
    bus.ram_wa   = '0;
    bus.ram_we   = 1'b0;
    bus.ram_wsel = 1'b0;
    bus.rom_addr = '0;
    bus.but_sel  = BS_NTT;
    bus.busy     = (r_state != S_IDLE);
    bus.done     = (r_state == S_FIN);
    if (r_state != S_IDLE) bus.but_sel = mode_to_bsel(r_mode);
    if (r_state == S_ISSUE) begin
      bus.ram_ra   = r_word;
      bus.rom_addr = ROMAWID'({r_pass, r_word});
    end
    if ((r_state == S_LOAD) && bus.data_vld) begin
      bus.ram_we = 1'b1;
      bus.ram_wa = r_beat;
    end else if (w_dly_vld) begin
      bus.ram_we   = 1'b1;
      bus.ram_wsel = 1'b1;
      bus.ram_wa   = w_dly_addr;
    end
  end

`ifdef POLY_SCHED_PERF_EN
  logic [15:0] r_perf;

  // Busy-cycle counter: cleared on start, frozen from FIN until the next start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf <= '0;
    end else if (w_start) begin
      r_perf <= '0;
    end else if ((r_state != S_IDLE) && (r_state != S_FIN) && (r_perf != 16'hFFFF)) begin
      r_perf <= r_perf + 16'd1;
    end
  end

  assign perf_cyc = r_perf;
`endif

endmodule

// File: tb/tb_poly_sched.sv
// Self-checking bench for poly_sched: a cycle-indexed behavioural model
// (job timing from plain arithmetic) is compared every cycle, plus literal
// expectations for job latencies and write counts.
module tb_poly_sched;

  localparam int ADDWID   = 5;
  localparam int NPASS    = 3;
  localparam int PIPE_LAT = 6;
  localparam int ROMAWID  = 7;
  localparam int NW       = 1 << ADDWID;
  localparam int L        = NW + PIPE_LAT;

  logic clk = 1'b0;
  logic rst = 1'b0;

  poly_sched_if #(.ADDWID(ADDWID), .ROMAWID(ROMAWID)) bus ();
`ifdef POLY_SCHED_PERF_EN
  logic [15:0] perf_cyc;
`endif

  poly_sched #(
    .ADDWID   (ADDWID),
    .NPASS    (NPASS),
    .PIPE_LAT (PIPE_LAT),
    .ROMAWID  (ROMAWID)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef POLY_SCHED_PERF_EN
    ,
    .perf_cyc (perf_cyc)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: job in flight, its mode, cycles since the run edge, beats taken.
  bit m_busy  = 1'b0;
  int m_mode  = 0;
  int m_t     = 0;
  int m_beats = 0;

  // Per-job observations of the DUT.
  int n_we, n_done, done_t, max_rom;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int job_len(input int md);
    return ((md == 3) ? 1 : NPASS) * L + 1;
  endfunction

  function automatic int bsel_of(input int md);
    return (md == 2) ? 1 : (md == 3) ? 2 : 0;
  endfunction

  task automatic clear_stats();
    n_we = 0; n_done = 0; done_t = -1; max_rom = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model at the edge.
  task automatic step(input bit r, input int md, input bit a, input bit dv);
    int e_ra, e_wa, e_we, e_wsel, e_rom, e_bsel, e_busy, e_done, p, w;
    bit e_issue;
    bus.run      = r;
    bus.mode     = md[1:0];
    bus.abort    = a;
    bus.data_vld = dv;
    #1;
    e_ra = 0; e_wa = 0; e_we = 0; e_wsel = 0; e_rom = 0; e_bsel = 0;
    e_busy = 0; e_done = 0; e_issue = 1'b0;
    if (m_busy) begin
      e_busy = 1;
      e_bsel = bsel_of(m_mode);
      if (m_mode == 0) begin
        if (m_beats == NW) e_done = 1;
        else if (dv) begin e_we = 1; e_wa = m_beats; end
      end else if (m_t == job_len(m_mode)) begin
        e_done = 1;
      end else begin
        p = (m_t - 1) / L;
        w = (m_t - 1) % L;
        if (w < NW) begin e_issue = 1'b1; e_ra = w; e_rom = p * NW + w; end
        if (w >= PIPE_LAT) begin e_we = 1; e_wsel = 1; e_wa = w - PIPE_LAT; end
      end
    end
    check("busy",    int'(bus.busy),    e_busy);
    check("done",    int'(bus.done),    e_done);
    check("ram_we",  int'(bus.ram_we),  e_we);
    check("but_sel", int'(bus.but_sel), e_bsel);
    if (e_issue) begin
      check("ram_ra",   int'(bus.ram_ra),   e_ra);
      check("rom_addr", int'(bus.rom_addr), e_rom);
    end
    if (e_we != 0) begin
      check("ram_wa",   int'(bus.ram_wa),   e_wa);
      check("ram_wsel", int'(bus.ram_wsel), e_wsel);
    end
    if (bus.ram_we === 1'b1) n_we++;
    if (bus.done === 1'b1) begin n_done++; done_t = m_t; end
    if ((bus.busy === 1'b1) && (int'(bus.rom_addr) > max_rom)) max_rom = int'(bus.rom_addr);
    @(posedge clk);
    if (a) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (r) begin m_busy = 1'b1; m_mode = md; m_t = 1; m_beats = 0; end
    end else if (m_mode == 0) begin
      if (m_beats == NW) m_busy = 1'b0;
      else begin m_t++; if (dv) m_beats++; end
    end else if (m_t == job_len(m_mode)) begin
      m_busy = 1'b0;
    end else begin
      m_t++;
    end
    @(negedge clk);
  endtask

  // Run the current job to completion with random run noise, data gaps and optional aborts.
  task automatic run_job(input int abort_per_mille);
    int guard = 0;
    bit rn, ab;
    while (m_busy && guard < 2000) begin
      rn = ($urandom_range(0, 7) == 0);
      ab = ($urandom_range(0, 999) < abort_per_mille);
      step(rn, $urandom_range(0, 3), ab, $urandom_range(0, 2) != 0);
      guard++;
    end
    if (guard >= 2000) check("job_timeout", guard, 0);
  endtask

  initial begin
    bus.run = 1'b0; bus.mode = 2'd0; bus.abort = 1'b0; bus.data_vld = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy",   int'(bus.busy),     0);
    check("rst_done",   int'(bus.done),     0);
    check("rst_we",     int'(bus.ram_we),   0);
    check("rst_rom",    int'(bus.rom_addr), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) step(0, 0, 0, 0);

    // Reset mid-ISSUE at pass 1, word 10, then a clean NTT job from pass 0.
    step(1, 1, 0, 0);
    while (m_t < 49) step(0, 0, 0, 0);
    bus.run = 1'b0; bus.abort = 1'b0; bus.data_vld = 1'b0;
    #1;
    check("mid_ra",  int'(bus.ram_ra),   10);
    check("mid_rom", int'(bus.rom_addr), 42);
    rst = 1'b0;
    #1;
    check("rstmid_ra",   int'(bus.ram_ra),   0);
    check("rstmid_wa",   int'(bus.ram_wa),   0);
    check("rstmid_we",   int'(bus.ram_we),   0);
    check("rstmid_wsel", int'(bus.ram_wsel), 0);
    check("rstmid_rom",  int'(bus.rom_addr), 0);
    check("rstmid_bsel", int'(bus.but_sel),  0);
    check("rstmid_busy", int'(bus.busy),     0);
    check("rstmid_done", int'(bus.done),     0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_busy = 1'b0;
    step(0, 0, 0, 0);

    // DATAIN load with gaps.
    clear_stats();
    step(1, 0, 0, 0);
    run_job(0);
    check("load_writes", n_we,   NW);
    check("load_dones",  n_done, 1);

    // NTT with defaults.
    clear_stats();
    step(1, 1, 0, 0);
    run_job(0);
    check("ntt_done_cyc", done_t,  115);
    check("ntt_writes",   n_we,    96);
    check("ntt_max_rom",  max_rom, 95);
    check("ntt_dones",    n_done,  1);
`ifdef POLY_SCHED_PERF_EN
    check("perf_after_done", int'(perf_cyc), 114);
    repeat (3) step(0, 0, 0, 0);
    check("perf_held", int'(perf_cyc), 114);
`endif

    // INTT.
    clear_stats();
    step(1, 2, 0, 0);
    run_job(0);
    check("intt_done_cyc", done_t, 115);

    // BYPASS: single pass.
    clear_stats();
    step(1, 3, 0, 0);
    run_job(0);
    check("byp_done_cyc", done_t,  39);
    check("byp_max_rom",  max_rom, 31);
    check("byp_writes",   n_we,    32);

    // Abort at pass 2, word 5.
    clear_stats();
    step(1, 1, 0, 0);
    while (m_t < 82) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    #1;
    check("abort_busy", int'(bus.busy),   0);
    check("abort_we",   int'(bus.ram_we), 0);
    repeat (10) step(0, 0, 0, 0);
    check("abort_dones", n_done, 0);

    // run and abort together in IDLE.
    step(1, 1, 1, 0);
    #1;
    check("runabort_busy", int'(bus.busy), 0);
    repeat (3) step(0, 0, 0, 0);

    // Randomized jobs with occasional aborts.
    for (int j = 0; j < 8; j++) begin
      step(1, $urandom_range(0, 3), 0, 0);
      run_job(4);
      repeat ($urandom_range(0, 3)) step(0, 0, 0, 0);
    end
    repeat (3) step(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
